mem_burst_master: RTL and testbench

//  Bus initiator for the 4096x16 single-port RAM: owns addr, rw and the shared tri-state data bus.

---
 rtl/mem_burst_master.sv | 133 +++++++++++++
 tb/tb_mem_burst_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port RAM: turns (addr, len, dir) commands into one access per clock.
// Optional MEMBUS_TURNAROUND_EN inserts one released-bus cycle after every write burst.
module mem_burst_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  inout  wire  [DATA_W-1:0] data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
`ifdef MEMBUS_TURNAROUND_EN
    , TURN = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // A pending read beat must drain before the next command, so beats never reorder.
  assign cmd_ready = (state_q == IDLE) && !rd_valid_q;
  assign wr_ready  = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign addr      = addr_q;
  assign rw        = rw_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign data      = rw_q ? wdata_q : {DATA_W{1'bz}};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = 1'b0;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          ptr_d = cmd_addr;
          cnt_d = cmd_len;
          if (cmd_wr) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            addr_d  = cmd_addr;
          end
        end
      end
      WRITE: begin
        // rw is high only in the cycle after an accepted beat; the RAM commits at the next edge.
        if (wr_valid) begin
          addr_d  = ptr_q;
          wdata_d = wr_data;
          rw_d    = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
`ifdef MEMBUS_TURNAROUND_EN
            state_d = TURN;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      READ: begin
        if (!rd_valid_q || rd_ready) begin
          rd_data_d  = data;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = IDLE;
        end
      end
`ifdef MEMBUS_TURNAROUND_EN
      TURN: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: RAM model on the shared bus, reference memory array and
// expectation queues drained by a negedge monitor.
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [11:0] cmd_addr = '0, cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b1;
  logic [15:0] rd_data;
  logic        busy, rw;
  logic [11:0] addr;
  wire  [15:0] data;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] ram [4096];
  logic [15:0] model_mem [4096];
  logic [27:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic        held_q = 1'b0;
  logic [15:0] held_data_q = '0;

  mem_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .addr(addr), .rw(rw), .data(data)
  );

  always #5 clk = ~clk;

  // The RAM: combinational read onto the bus while rw==0, write at the edge while rw==1.
  assign data = rw ? 16'hzzzz : ram[addr];
  always @(posedge clk) if (rw) ram[addr] <= data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held_q <= 1'b0;
    end else begin
      if (rw) begin
        if (exp_wr.size() == 0) chk("wr_pending", 32'(exp_wr.size()), 1);
        else chk("wr_beat", 32'({addr, data}), 32'(exp_wr.pop_front()));
      end
      if (held_q) begin
        chk("stall_data", 32'(rd_data), 32'(held_data_q));
        chk("stall_valid", 32'(rd_valid), 1);
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_pending", 32'(exp_rd.size()), 1);
        else chk("rd_beat", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
      held_q      <= rd_valid && !rd_ready;
      held_data_q <= rd_data;
    end
  end

  task automatic do_cmd(input logic wr, input logic [11:0] a, input logic [11:0] len);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // nb beats of a len+1 burst; gap bit k idles attempt k; step==0 means random data.
  task automatic wr_burst(input logic [11:0] a, input int len, input int nb,
                          input logic [31:0] gap, input logic [15:0] base, input logic [15:0] step);
    int i = 0;
    int att = 0;
    logic prev_acc = 1'b0, have = 1'b0;
    logic [11:0] last_a = '0;
    logic [15:0] d;
    do_cmd(1'b1, a, 12'(len));
    while (i < nb && att < 20000) begin
      d = (step == 0) ? 16'($urandom) : 16'(base + step * 16'(i));
      wr_valid = !(att < 32 && gap[att]);
      wr_data  = d;
      @(negedge clk);
      chk("rw_pattern", 32'(rw), 32'(prev_acc));
      if (!prev_acc && have) chk("addr_hold", 32'(addr), 32'(last_a));
      if (prev_acc) begin last_a = addr; have = 1'b1; end
      prev_acc = wr_valid && wr_ready;
      if (prev_acc) begin
        model_mem[12'(a + 12'(i))] = d;
        exp_wr.push_back({12'(a + 12'(i)), d});
      end
      @(posedge clk); #1;
      if (prev_acc) i++;
      att++;
    end
    if (i < nb) chk("wr_timeout", 32'(i), 32'(nb));
    wr_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low 3 cycles after beat 2
  task automatic rd_burst(input logic [11:0] a, input int len, input int mode);
    int got = 0, cyc = 0, st = 0;
    for (int i = 0; i <= len; i++) exp_rd.push_back(model_mem[12'(a + 12'(i))]);
    do_cmd(1'b0, a, 12'(len));
    while (got <= len && cyc < 20000) begin
      if (mode == 2) begin
        rd_ready = !(got == 2 && st < 3);
        if (!rd_ready) st++;
      end else begin
        rd_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("rd_lat0", 32'(rd_valid), 0);
        chk("rd_busy", 32'(busy), 1);
        chk("rd_rw_low", 32'(rw), 0);
      end
      if (cyc == 1) chk("rd_lat1", 32'(rd_valid), 1);
      if (rd_valid && rd_ready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    if (got <= len) chk("rd_timeout", 32'(got), 32'(len + 1));
    rd_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int len;
    #13;
    chk("rst_rw", 32'(rw), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", 32'(cmd_ready), 1);

    // Fill every word through the master: maximum length burst, ends with wrap to 0.
    wr_burst(12'h000, 4095, 4096, 32'h0, 16'h0, 16'h0);

    wr_burst(12'h3FE, 3, 4, 32'h0, 16'hA000, 16'h1);
    rd_burst(12'h3FE, 3, 0);

    wr_burst(12'hFFF, 1, 2, 32'h0, 16'h1111, 16'h1111);
    rd_burst(12'hFFF, 1, 0);

    wr_burst(12'h080, 1, 2, 32'h2, 16'h0, 16'h0);
    rd_burst(12'h07F, 3, 0);

    rd_burst(12'h100, 7, 2);

    // Reset while the third of four beats is on the bus: only two words may change.
    wr_burst(12'h200, 3, 2, 32'h0, 16'h0, 16'h0);
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    @(posedge clk); #2;
    chk("rw_before_rst", 32'(rw), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rw", 32'(rw), 0);
    chk("async_addr", 32'(addr), 0);
    chk("async_busy", 32'(busy), 0);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_burst(12'h200, 3, 0);

    for (int n = 0; n < 40; n++) begin
      a   = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + 12'($urandom_range(0, 7))) : 12'($urandom);
      len = $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) wr_burst(a, len, len + 1, $urandom & $urandom, 16'h0, 16'h0);
      else rd_burst(a, len, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("wr_q_empty", 32'(exp_wr.size()), 0);
    chk("rd_q_empty", 32'(exp_rd.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
